// File: rtl/ssl_result_tx.sv
// Serial result transmitter: frames sync + three delay indices into 8N1 bytes, LSB first.
// Optional checksum byte enabled by defining SSL_TX_CHECKSUM_EN.
module ssl_result_tx #(
   parameter int NDATA     = 128,
   parameter int NDATA_LOG = $clog2(NDATA),
   parameter int CLKDIV    = 434
) (
   input  logic                 clk,
   input  logic                 erst,
   input  logic                 strb,
   input  logic [NDATA_LOG-1:0] dIdA,
   input  logic [NDATA_LOG-1:0] dIdB,
   input  logic [NDATA_LOG-1:0] dIdC,
   output logic                 txd,
   output logic                 busy,
   output logic                 drop
);

   if (NDATA_LOG > 8) begin : g_bad_width
      $error("ssl_result_tx: NDATA_LOG must be <= 8");
   end
   if (CLKDIV < 2) begin : g_bad_div
      $error("ssl_result_tx: CLKDIV must be >= 2");
   end

`ifdef SSL_TX_CHECKSUM_EN
   localparam int NBYTES = 5;
`else
   localparam int NBYTES = 4;
`endif

   localparam int                DIV_W    = $clog2(CLKDIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);
   localparam logic [2:0]        BYTE_LAST = 3'(NBYTES - 1);
   localparam logic [7:0]        SYNC     = 8'hA5;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [2:0]       byte_q, byte_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             drop_q, drop_d;
   logic             bit_end;
   logic [7:0]       nxt_byte;

   // Byte that follows the one currently indexed by byte_q.
   always_comb begin
      nxt_byte = '1;
      case (byte_q)
         3'd0:    nxt_byte = a_q;
         3'd1:    nxt_byte = b_q;
         3'd2:    nxt_byte = c_q;
`ifdef SSL_TX_CHECKSUM_EN
         3'd3:    nxt_byte = a_q ^ b_q ^ c_q;
`endif
         default: nxt_byte = '1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      sh_d    = sh_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      drop_d  = strb & busy_q;
      bit_end = (div_q == DIV_LAST);

      if (state_q != IDLE) begin
         div_d = bit_end ? '0 : div_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (strb) begin
               a_d     = 8'(dIdA);
               b_d     = 8'(dIdB);
               c_d     = 8'(dIdC);
               sh_d    = SYNC;
               div_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               txd_d   = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  txd_d = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (byte_q == BYTE_LAST) begin
                  busy_d  = 1'b0;
                  byte_d  = '0;
                  state_d = IDLE;
               end else begin
                  txd_d   = 1'b0;
                  sh_d    = nxt_byte;
                  byte_d  = byte_q + 3'd1;
                  state_d = START;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge erst) begin
      if (!erst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         sh_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         sh_q    <= sh_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign txd  = txd_q;
   assign busy = busy_q;
   assign drop = drop_q;

endmodule

// File: doc/ssl_result_tx.md
# ssl_result_tx

Serial result transmitter for the sound source localization datapath. It captures the three delay indices produced by the processor arrays (channels A, B and C) on a result strobe. It frames them into bytes and shifts them out on a single UART-style TX line (8N1, LSB first) to the host. It sits at the output boundary of the design as the consumer of the delay-index bus, alongside the output processing path.

## Interface
- `NDATA`, 128, number of samples per correlation window; sets the index range.
- `NDATA_LOG`, `$clog2(NDATA)`, delay index width. Must be ≤ 8; elaboration fails otherwise.
- `CLKDIV`, 434, clock cycles per serial bit. Must be ≥ 2; elaboration fails otherwise.

- `clk`  in  1  system clock; all logic on the rising edge.
- `erst`  in  1  reset, asynchronous assert, active-low.
- `strb`  in  1  one-cycle pulse: `dIdA`/`dIdB`/`dIdC` hold a new result this cycle.
- `dIdA`  in  NDATA_LOG  delay index, channel A.
- `dIdB`  in  NDATA_LOG  delay index, channel B.
- `dIdC`  in  NDATA_LOG  delay index, channel C.
- `txd`  out  1  serial output; idle high.
- `busy`  out  1  frame in progress.
- `drop`  out  1  one-cycle pulse: `strb` arrived while `busy` was high and was ignored.

## Operation
- **Reset values:**
  - `txd` = 1, `busy` = 0, `drop` = 0.
  - FSM is in IDLE.
  - Bit counter, byte counter and divider are 0.
- **Frame format**, in transmission order:
  - sync byte 0xA5,
  - `dIdA`, zero-extended to 8 bits,
  - `dIdB`, zero-extended to 8 bits,
  - `dIdC`, zero-extended to 8 bits,
  - optional checksum byte (see Configuration).
- **Byte format:** start bit 0, 8 data bits LSB first, stop bit 1.
- **Capture:**
  - `strb` while `busy` = 0 latches all three indices into internal registers.
  - Later input changes have no effect on the frame in flight.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on accepted `strb`.
  - START → DATA after `CLKDIV` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if bytes remain; STOP → IDLE after the final byte's stop bit.
- **Divider:** counts 0..`CLKDIV`-1 per bit and wraps to 0 at each bit boundary.
- **Byte counter:** counts 0..NBYTES-1.
- **Dropped strobe:** `strb` with `busy` = 1 raises `drop` for exactly one cycle. The frame in flight is unaltered and the strobe is not queued.
- **Reset mid-frame:** `txd` returns to 1 asynchronously and the frame is abandoned. No partial frame resumes after reset release.

## Timing
- **Start of frame:** `strb` sampled at edge N → `busy` = 1 and `txd` = 0 (start bit) from edge N+1.
- **Bit duration:** each bit holds for exactly `CLKDIV` cycles.
- **Frame length:** NBYTES × 10 × `CLKDIV` cycles. NBYTES = 5 with checksum, 4 without.
- **End of frame:** `busy` falls on the same edge the final stop bit ends. `txd` stays 1.
- **Back-to-back frames:**
  - `strb` in the first cycle with `busy` = 0 is accepted; the next start bit begins one cycle later.
  - `strb` in the last cycle of the final stop bit sees `busy` = 1 and is dropped.
- **Drop timing:** `drop` is registered. It pulses the cycle after the ignored `strb`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SSL_TX_CHECKSUM_EN`
  - **Defined:** a fifth byte is appended, equal to the bitwise XOR of the three zero-extended index bytes (sync byte excluded). NBYTES = 5.
  - **Undefined:** no checksum logic or byte. NBYTES = 4, and the frame ends after the `dIdC` stop bit.

## Test plan
- **Single frame:** `CLKDIV`=4, `SSL_TX_CHECKSUM_EN` defined, `dIdA`=0x05, `dIdB`=0x7F, `dIdC`=0x00, one `strb` pulse.
  - Decoded bytes: A5, 05, 7F, 00, 7A.
  - `busy` high for exactly 200 cycles.
  - `txd` = 0 on the cycle after `strb`.
- **Checksum disabled:** same stimulus with the macro undefined.
  - Decoded bytes: A5, 05, 7F, 00.
  - `busy` high for exactly 160 cycles.
- **Strobe while busy:** second `strb` at cycle 50 of a frame, with different index values.
  - `drop` pulses once.
  - Frame bytes are unchanged; no second frame follows.
- **Input change after capture:** change `dIdA` to 0x3C one cycle after an accepted `strb`.
  - Transmitted A byte remains 0x05.
- **Back-to-back:** `strb` on the first cycle `busy` = 0.
  - Second frame's start bit begins one cycle later; `drop` stays 0.
  - Repeating with `strb` one cycle earlier → `drop` pulses and no second frame is sent.
- **Reset mid-frame:** assert `erst` low during a data bit of the `dIdB` byte.
  - `txd` = 1 and `busy` = 0 immediately.
  - After release, no activity until the next `strb`, which sends a complete frame.
